// File: rtl/regfile_dump_ctrl.sv
// Run controller: counts a cycle budget while logging regfile writebacks into a
// commit FIFO, then drains it and sweeps every register out on one result stream.
module regfile_dump_ctrl #(
   parameter int NUM_REGS   = 32,
   parameter int DATA_W     = 32,
   parameter int CYC_W      = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   input  logic              rwe,
   input  logic [4:0]        rd,
   input  logic [DATA_W-1:0] rData,
   input  logic [4:0]        rs1_proc,
   output logic [4:0]        rs1_out,
   input  logic [DATA_W-1:0] regA,
   output logic              test_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_kind,
   output logic [4:0]        out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic [CYC_W-1:0]  out_cycle,
   output logic              overflow,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [4:0]        idx;
      logic [DATA_W-1:0] data;
      logic [CYC_W-1:0]  cyc;
   } rec_t;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP_ADDR, DUMP_OUT, DONE} state_t;

   state_t            state, state_nx;
   rec_t              fifo_mem [FIFO_DEPTH];
   rec_t              head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic [CYC_W-1:0]  budget, counter;
   logic [4:0]        index;
   logic [DATA_W-1:0] dump_data;
   logic              fifo_empty, fifo_full, commit_phase;
   logic              push_req, push, pop, last_reg;

   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign commit_phase = (state == RUN) || (state == DRAIN);
   assign head         = fifo_mem[rd_ptr];
   assign pop          = commit_phase && !fifo_empty && out_ready;
   assign push_req     = (state == RUN) && rwe && (rd != 5'd0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push         = push_req && (!fifo_full || pop);
   assign last_reg     = (index == 5'(NUM_REGS-1));

   assign test_mode = (state == DUMP_ADDR) || (state == DUMP_OUT) || (state == DONE);
   assign done      = (state == DONE);
   assign rs1_out   = test_mode ? index : rs1_proc;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = (num_cycles == '0) ? DRAIN : RUN;
         RUN:       if (counter == budget - CYC_W'(1)) state_nx = DRAIN;
         DRAIN:     if (fifo_empty) state_nx = DUMP_ADDR;
         DUMP_ADDR: state_nx = DUMP_OUT;
         DUMP_OUT:  if (out_ready) state_nx = last_reg ? DONE : DUMP_ADDR;
         DONE:      state_nx = DONE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_kind  = 1'b0;
      out_idx   = '0;
      out_data  = '0;
      out_cycle = '0;
      if (commit_phase) begin
         out_valid = !fifo_empty;
         out_idx   = head.idx;
         out_data  = head.data;
         out_cycle = head.cyc;
      end else if (state == DUMP_OUT) begin
         out_valid = 1'b1;
         out_kind  = 1'b1;
         out_idx   = index;
         out_data  = dump_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         budget    <= '0;
         counter   <= '0;
         index     <= '0;
         dump_data <= '0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            budget  <= num_cycles;
            counter <= '0;
         end else if (state == RUN) begin
            counter <= counter + CYC_W'(1);
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (push_req && !push) overflow <= 1'b1;
         // regA has had the whole settle cycle to respond to the sweep address.
         if (state == DUMP_ADDR) dump_data <= regA;
         if (state == DUMP_OUT && out_ready && !last_reg) index <= index + 5'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {rd, rData, counter};
   end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: directed and random run scenarios checked against
// an expected-record queue built from the capture and dump rules.
module tb_regfile_dump_ctrl;
   localparam int NR = 32, DW = 32, CW = 8, FD = 8;

   logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
   logic [CW-1:0] num_cycles = '0;
   logic          rwe = 1'b0, out_ready = 1'b0;
   logic [4:0]    rd = '0, rs1_proc = '0;
   logic [DW-1:0] rData = '0;
   logic [4:0]    rs1_out, out_idx;
   logic [DW-1:0] regA, out_data;
   logic [CW-1:0] out_cycle;
   logic          test_mode, out_valid, out_kind, overflow, done;

   regfile_dump_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .CYC_W(CW), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
      .rwe(rwe), .rd(rd), .rData(rData), .rs1_proc(rs1_proc), .rs1_out(rs1_out),
      .regA(regA), .test_mode(test_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_kind(out_kind), .out_idx(out_idx), .out_data(out_data), .out_cycle(out_cycle),
      .overflow(overflow), .done(done));

   always #5 clock = ~clock;

   // Environment regfile; x0 is never written.
   logic [DW-1:0] regs [NR];
   assign regA = regs[rs1_out];

   logic [45:0] cur;
   assign cur = {out_kind, out_idx, out_data, out_cycle};

   int          n_chk = 0, n_fail = 0;
   logic [45:0] exp_q [$];
   logic [45:0] held_rec, tmp;
   logic        held, exp_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; start = 1'b0; rwe = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      held = 1'b0; exp_ovf = 1'b0; exp_q.delete();
      for (int i = 0; i < NR; i++) regs[i] = '0;
      rs1_proc = 5'($urandom);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_tmode", test_mode, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rs1", rs1_out, rs1_proc);
      reset = 1'b1;
   endtask

   // One clock: drive, sample at the falling edge, update the expected queue.
   task automatic cyc(input logic st, input logic we, input logic [4:0] r, input logic [DW-1:0] d,
                      input logic rdy, input logic in_run, input logic [CW-1:0] stamp);
      logic pop;
      int   sz;
      start = st; rwe = we; rd = r; rData = d; out_ready = rdy; rs1_proc = 5'($urandom);
      @(negedge clock);
      if (in_run) begin
         chk("run_valid", out_valid, exp_q.size() > 0);
         chk("run_rs1", rs1_out, rs1_proc);
      end
      if (held) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_rec", cur, held_rec);
      end
      pop = out_valid && out_ready;
      sz  = exp_q.size();
      if (pop) begin
         if (sz == 0) chk("extra_rec", out_valid, 0);
         else begin
            chk("rec", cur, exp_q[0]);
            tmp = exp_q.pop_front();
            if (out_kind) chk("dump_rs1", rs1_out, out_idx);
         end
      end
      held = out_valid && !out_ready;
      held_rec = cur;
      if (in_run && we && r != 5'd0) begin
         if (sz < FD || pop) exp_q.push_back({1'b0, r, d, stamp});
         else exp_ovf = 1'b1;
      end
      @(posedge clock);
      if (we && r != 5'd0) regs[r] = d;
      #1;
   endtask

   // mode 0 directed, 1 overflow, 2 full push+pop, 3 random
   task automatic scenario(input int budget, input int mode, input int abort_idx);
      logic we, rdy, aborted;
      logic [4:0] r;
      logic [DW-1:0] d;
      do_reset();
      num_cycles = CW'(budget);
      cyc(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1, '0);
      num_cycles = CW'($urandom);
      for (int c = 0; c < budget; c++) begin
         we = 1'b0; r = '0; d = '0; rdy = 1'b0;
         case (mode)
            0: begin
               rdy = 1'b1;
               if (c == 2) begin we = 1'b1; r = 5'd1; d = 32'd5; end
               if (c == 4) begin we = 1'b1; r = 5'd2; d = 32'd7; end
               if (c == 6) begin we = 1'b1; r = 5'd0; d = 32'd99; end
            end
            1: if (c < 10) begin we = 1'b1; r = 5'(c + 1); d = 32'h100 + c; end
            2: begin
               if (c < 9) begin we = 1'b1; r = 5'(c + 1); d = 32'h200 + c; end
               rdy = (c == 8);
            end
            default: begin
               we = 1'($urandom); r = 5'($urandom); d = $urandom; rdy = 1'($urandom);
            end
         endcase
         cyc(1'b0, we, r, d, rdy, 1'b1, CW'(c));
      end
      for (int i = 0; i < NR; i++) exp_q.push_back({1'b1, 5'(i), regs[i], 8'd0});
      aborted = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (abort_idx >= 0 && out_valid && out_kind && out_idx == 5'(abort_idx)) begin
            aborted = 1'b1;
            break;
         end
         if (exp_q.size() == 0 && done) break;
         case (mode)
            0:       rdy = 1'b1;
            3:       rdy = k[0];
            default: rdy = 1'($urandom);
         endcase
         cyc(1'b0, 1'b0, 5'd0, '0, rdy, 1'b0, '0);
      end
      if (abort_idx >= 0) begin
         chk("abort_reached", aborted, 1);
         reset = 1'b0; out_ready = 1'b0; rs1_proc = 5'($urandom);
         @(posedge clock);
         #1;
         chk("abort_valid", out_valid, 0);
         chk("abort_tmode", test_mode, 0);
         chk("abort_rs1", rs1_out, rs1_proc);
         chk("abort_done", done, 0);
         held = 1'b0;
      end else begin
         chk("drained", exp_q.size(), 0);
         chk("done", done, 1);
         chk("overflow", overflow, exp_ovf);
         cyc(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0, '0);
         chk("done_hold", done, 1);
         chk("done_tmode", test_mode, 1);
         chk("done_valid", out_valid, 0);
      end
   endtask

   initial begin
      held = 1'b0; exp_ovf = 1'b0;
      for (int i = 0; i < NR; i++) regs[i] = '0;
      scenario(10, 0, -1);
      scenario(12, 1, -1);
      chk("ovf_expected", exp_ovf, overflow);
      scenario(12, 2, -1);
      scenario(0, 3, -1);
      scenario(1, 3, -1);
      for (int t = 0; t < 3; t++) scenario(8 + int'($urandom_range(0, 32)), 3, -1);
      scenario(10, 0, 12);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
